// File: rtl/freq_pkg.sv
// Shared BCD definitions for the frequency-meter counter datapath.
package freq_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One decade (0-9) counter stage of the live BCD cascade.
// carry_out tells the next decade to advance when this one wraps.
module bcd_digit
    import freq_pkg::*;
(
    input  logic       clk,
    input  logic       CR,
    input  logic       clr,
    input  logic       inc_in,
    output bcd_digit_t q,
    output logic       carry_out
);

    bcd_digit_t q_q;

    // Decade register: reset and clear dominate an increment.
    always_ff @(posedge clk) begin
        if (CR) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (inc_in) begin
            q_q <= (q_q == BCD_MAX) ? bcd_digit_t'(0) : q_q + 4'd1;
        end
    end

    assign q         = q_q;
    assign carry_out = inc_in & (q_q == BCD_MAX);

endmodule

// File: rtl/freq_count.sv
// Gated BCD edge counter: counts synchronized rising edges of sig_in between
// the window clear (en_count low) and latch (en_latch high) pulses.
// Optional build macro FREQ_COUNT_SAT_EN: saturate at all 9s instead of wrapping.
module freq_count
    import freq_pkg::*;
#(
    parameter int unsigned DIGITS      = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    CR,
    input  logic                    sig_in,
    input  logic                    en_count,
    input  logic                    en_latch,
    output logic [BCD_W*DIGITS-1:0] bcd_out,
    output logic                    ovf,
    output logic                    data_valid
);

    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    edge_q;
    logic                    inc;
    logic                    inc_cnt;
    logic                    ovf_set;
    logic                    ovf_live_q;
    logic [DIGITS-1:0]       carry;
    bcd_digit_t              digit_q [DIGITS];
    logic [BCD_W*DIGITS-1:0] live;
    logic [BCD_W*DIGITS-1:0] bcd_q;
    logic                    ovf_q;
    logic                    valid_q;

    // Synchronizer chain plus edge-history flop; reset leaves both at 0 so no edge is seen.
    always_ff @(posedge clk) begin
        if (CR) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign inc = sync_q[SYNC_STAGES-1] & ~edge_q;

`ifdef FREQ_COUNT_SAT_EN
    logic [DIGITS-1:0] nine;
    logic              all_nine;

    assign all_nine = &nine;
    // Holding inc off at all 9s freezes the cascade, so the top carry never fires here.
    assign inc_cnt  = inc & ~all_nine;
    assign ovf_set  = (inc & all_nine) | carry[DIGITS-1];
`else
    assign inc_cnt  = inc;
    assign ovf_set  = carry[DIGITS-1];
`endif

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic inc_k;

        if (k == 0) begin : g_lsd
            assign inc_k = inc_cnt;
        end else begin : g_upper
            assign inc_k = carry[k-1];
        end

        bcd_digit u_digit (
            .clk       (clk),
            .CR        (CR),
            .clr       (~en_count),
            .inc_in    (inc_k),
            .q         (digit_q[k]),
            .carry_out (carry[k])
        );

        assign live[k*BCD_W +: BCD_W] = digit_q[k];

`ifdef FREQ_COUNT_SAT_EN
        assign nine[k] = (digit_q[k] == BCD_MAX);
`endif
    end

    // Sticky overflow of the live window; clear wins over a same-cycle overflow.
    always_ff @(posedge clk) begin
        if (CR) begin
            ovf_live_q <= 1'b0;
        end else if (!en_count) begin
            ovf_live_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_live_q <= 1'b1;
        end
    end

    // Output latch captures pre-update live values; valid pulses the cycle after.
    always_ff @(posedge clk) begin
        if (CR) begin
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en_latch;
            if (en_latch) begin
                bcd_q <= live;
                ovf_q <= ovf_live_q;
            end
        end
    end

    assign bcd_out    = bcd_q;
    assign ovf        = ovf_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_freq_count.sv
// Bench for freq_count: a 6-digit and a 2-digit instance share all stimulus and
// are compared every cycle against an integer-count reference model.
module tb_freq_count;

    localparam int unsigned S = 2;
`ifdef FREQ_COUNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        cr;
    logic        sig;
    logic        en_count;
    logic        en_latch;
    logic [23:0] bcd6;
    logic [7:0]  bcd2;
    logic        ovf6, ovf2, dv6, dv2;

    always #5 clk = ~clk;

    freq_count #(.DIGITS(6), .SYNC_STAGES(S)) u_dut6 (
        .clk        (clk),
        .CR         (cr),
        .sig_in     (sig),
        .en_count   (en_count),
        .en_latch   (en_latch),
        .bcd_out    (bcd6),
        .ovf        (ovf6),
        .data_valid (dv6)
    );

    freq_count #(.DIGITS(2), .SYNC_STAGES(S)) u_dut2 (
        .clk        (clk),
        .CR         (cr),
        .sig_in     (sig),
        .en_count   (en_count),
        .en_latch   (en_latch),
        .bcd_out    (bcd2),
        .ovf        (ovf2),
        .data_valid (dv2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: sampled-input history, integer live counts, latched outputs.
    bit hist [0:S];
    int cnt6 = 0, cnt2 = 0, out6 = 0, out2 = 0;
    bit ovl6 = 0, ovl2 = 0, ovo6 = 0, ovo2 = 0, dv_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd6(input logic [23:0] b);
        int v;
        v = 0;
        for (int i = 5; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    task automatic bump(inout int c, inout bit o, input int maxv);
        if (c == maxv) begin
            o = 1'b1;
            c = SAT ? maxv : 0;
        end else begin
            c = c + 1;
        end
    endtask

    // A rise sampled S edges ago (previous sample low) counts at this edge.
    task automatic model_step();
        bit inc;
        if (cr) begin
            for (int k = 0; k <= S; k++) hist[k] = 1'b0;
            cnt6 = 0; cnt2 = 0; ovl6 = 0; ovl2 = 0;
            out6 = 0; out2 = 0; ovo6 = 0; ovo2 = 0; dv_m = 0;
            return;
        end
        inc  = hist[S-1] && !hist[S];
        dv_m = en_latch;
        if (en_latch) begin
            out6 = cnt6; ovo6 = ovl6;
            out2 = cnt2; ovo2 = ovl2;
        end
        if (!en_count) begin
            cnt6 = 0; cnt2 = 0; ovl6 = 0; ovl2 = 0;
        end else if (inc) begin
            bump(cnt6, ovl6, 999999);
            bump(cnt2, ovl2, 99);
        end
        for (int k = S; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = sig;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("bcd6", 32'(bcd6), to_bcd(out6));
        check("ovf6", 32'(ovf6), 32'(ovo6));
        check("dv6",  32'(dv6),  32'(dv_m));
        check("bcd2", 32'(bcd2), to_bcd(out2));
        check("ovf2", 32'(ovf2), 32'(ovo2));
        check("dv2",  32'(dv2),  32'(dv_m));
    endtask

    task automatic run_sig(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            sig = 1'b1;
            repeat (hi) tick();
            sig = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic flush();
        sig = 1'b0;
        repeat (S + 2) tick();
    endtask

    task automatic pulse_clear();
        en_count = 1'b0;
        tick();
        en_count = 1'b1;
    endtask

    task automatic pulse_latch();
        en_latch = 1'b1;
        tick();
        en_latch = 1'b0;
    endtask

    task automatic window(input int n, input int hi, input int lo, input bit do_clear);
        if (do_clear) pulse_clear();
        run_sig(n, hi, lo);
        flush();
        pulse_latch();
    endtask

    initial begin
        cr       = 1'b1;
        sig      = 1'b0;
        en_count = 1'b1;
        en_latch = 1'b0;
        repeat (2) tick();
        check("rst_bcd6", 32'(bcd6), 32'h0);
        check("rst_dv",   32'(dv6),  32'h0);
        cr = 1'b0;
        tick();

        // Basic count, data_valid one cycle only
        window(100, 2, 2, 1'b1);
        check("basic_bcd", 32'(bcd6), 32'h000100);
        check("basic_ovf", 32'(ovf6), 32'h0);
        check("basic_dv",  32'(dv6),  32'h1);
        tick();
        check("basic_dv_low", 32'(dv6), 32'h0);

        // Carry ripple
        window(999, 2, 2, 1'b1);
        check("ripple_999", 32'(bcd6), 32'h000999);
        window(1000, 2, 2, 1'b1);
        check("ripple_1000", 32'(bcd6), 32'h001000);

        // Overflow on the 2-digit instance
        window(105, 2, 2, 1'b1);
        check("ovf_bcd2", 32'(bcd2), SAT ? 32'h99 : 32'h05);
        check("ovf_flag2", 32'(ovf2), 32'h1);
        window(3, 2, 2, 1'b1);
        check("ovf_next_bcd2", 32'(bcd2), 32'h03);
        check("ovf_next_flag2", 32'(ovf2), 32'h0);

        // inc coincident with latch: excluded now, visible in next latch without clear
        pulse_clear();
        run_sig(5, 2, 2);
        flush();
        sig = 1'b1;
        repeat (S) tick();
        en_latch = 1'b1;
        tick();
        en_latch = 1'b0;
        check("latch_coinc", 32'(bcd6), 32'h000005);
        flush();
        pulse_latch();
        check("latch_coinc_next", 32'(bcd6), 32'h000006);

        // inc coincident with clear: edge dropped
        pulse_clear();
        run_sig(4, 2, 2);
        flush();
        sig = 1'b1;
        repeat (S) tick();
        en_count = 1'b0;
        tick();
        en_count = 1'b1;
        flush();
        pulse_latch();
        check("clear_coinc", 32'(bcd6), 32'h000000);

        // Simultaneous clear and latch: latch sees pre-clear value
        run_sig(12, 2, 2);
        flush();
        en_count = 1'b0;
        en_latch = 1'b1;
        tick();
        en_count = 1'b1;
        en_latch = 1'b0;
        check("clr_latch_pre", 32'(bcd6), 32'h000012);
        pulse_latch();
        check("clr_latch_post", 32'(bcd6), 32'h000000);

        // Reset mid-window
        pulse_clear();
        run_sig(50, 2, 2);
        cr = 1'b1;
        tick();
        check("rst_mid_bcd", 32'(bcd6), 32'h0);
        check("rst_mid_ovf", 32'(ovf6), 32'h0);
        check("rst_mid_dv",  32'(dv6),  32'h0);
        cr = 1'b0;
        run_sig(7, 2, 2);
        flush();
        pulse_latch();
        check("rst_mid_count", 32'(bcd6), 32'h000007);

        // Sampling limit: f_clk/2 never overcounts, f_clk/4 is exact
        window(30, 1, 1, 1'b1);
        check("fhalf_le", 32'(from_bcd6(bcd6) <= 30), 32'h1);
        window(30, 2, 2, 1'b1);
        check("fquarter", 32'(bcd6), 32'h000030);

        // Randomized windows, sometimes free-running without clear
        for (int w = 0; w < 25; w++) begin
            window(int'($urandom_range(0, 60)), int'($urandom_range(1, 4)),
                   int'($urandom_range(1, 4)), $urandom_range(0, 3) != 0);
            check("rand_bcd6", 32'(bcd6), to_bcd(out6));
            check("rand_bcd2", 32'(bcd2), to_bcd(out2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
